pe_mac_acc: RTL and testbench

//  Parametrised signed MAC processing element; next generation of the 8-bit PE used in the PE array.
//  - Width-generic operands; wide partial sum; fully pipelined (1 beat/cycle).
//  - Per-beat mode: pass-through psum add, or local accumulation over a beat group.
//  - Sits in the array between the data/weight broadcast and the psum chain/output buffer.

---
 rtl/pe_pkg.sv | 13 +
 rtl/pe_mult.sv | 32 +++
 rtl/pe_mac_acc.sv | 170 +++++++++++++++++
 tb/tb_pe_mac_acc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE-array package: beat modes and default datapath widths.
// Optional build macro used by the PE: PE_SATURATE_EN.
package pe_pkg;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_PSUM_W   = 24;
  localparam int DEF_MUL_LAT  = 3;

endpackage

// File: rtl/pe_mult.sv
// Signed pipelined multiplier, full-precision product after LAT stages.
// Stage 0 holds the raw product; later stages only delay it.
module pe_mult #(
  parameter int A_W = 8,
  parameter int B_W = 8,
  parameter int LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [A_W-1:0]      a,
  input  logic signed [B_W-1:0]      b,
  output logic signed [A_W+B_W-1:0]  p
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] stg [LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= P_W'($signed(a)) * P_W'($signed(b));
      for (int i = 1; i < LAT; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign p = stg[LAT-1];

endmodule

// File: rtl/pe_mac_acc.sv
// Signed MAC PE: capture, pipelined multiply, psum add or group accumulate.
// Define PE_SATURATE_EN to clamp overflowing sums instead of wrapping.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int PSUM_W   = DEF_PSUM_W,
  parameter int MUL_LAT  = DEF_MUL_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_data_val,
  input  logic [WEIGHT_W-1:0] i_weight,
  input  logic                i_weight_val,
  input  logic [PSUM_W-1:0]   i_psum,
  input  logic                i_mode,
  input  logic                i_last,
  output logic [PSUM_W-1:0]   o_psum,
  output logic                o_psum_val,
  output logic                o_ovf
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int SUM_W  = PSUM_W + 1;

  logic [DATA_W-1:0]   d_q;
  logic [WEIGHT_W-1:0] w_q;
  logic [PSUM_W-1:0]   p_q;
  logic                m_q;
  logic                l_q;
  logic                v_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= '0;
      w_q <= '0;
      p_q <= '0;
      m_q <= MODE_PASS;
      l_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      v_q <= i_data_val;
      if (i_data_val) begin
        d_q <= i_data;
        p_q <= i_psum;
        m_q <= i_mode;
        l_q <= i_last;
      end
      if (i_weight_val)
        w_q <= i_weight;
    end
  end

  logic signed [PROD_W-1:0] prod;

  pe_mult #(
    .A_W (DATA_W),
    .B_W (WEIGHT_W),
    .LAT (MUL_LAT)
  ) u_mult (
    .clk (clk),
    .rst (rst),
    .a   (d_q),
    .b   (w_q),
    .p   (prod)
  );

  logic              sb_v [MUL_LAT];
  logic [PSUM_W-1:0] sb_p [MUL_LAT];
  logic              sb_m [MUL_LAT];
  logic              sb_l [MUL_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        sb_v[i] <= 1'b0;
        sb_p[i] <= '0;
        sb_m[i] <= MODE_PASS;
        sb_l[i] <= 1'b0;
      end
    end else begin
      sb_v[0] <= v_q;
      sb_p[0] <= p_q;
      sb_m[0] <= m_q;
      sb_l[0] <= l_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_p[i] <= sb_p[i-1];
        sb_m[i] <= sb_m[i-1];
        sb_l[i] <= sb_l[i-1];
      end
    end
  end

  logic              sv;
  logic [PSUM_W-1:0] sp;
  logic              sm;
  logic              sl;

  assign sv = sb_v[MUL_LAT-1];
  assign sp = sb_p[MUL_LAT-1];
  assign sm = sb_m[MUL_LAT-1];
  assign sl = sb_l[MUL_LAT-1];

  logic [PSUM_W-1:0] acc_q;
  logic              acc_ovf_q;
  logic              open_q;

  logic [PSUM_W-1:0] base;
  logic [SUM_W-1:0]  sum;
  logic              ovf;
  logic [PSUM_W-1:0] res;
  logic              grp_ovf;

  localparam logic [PSUM_W-1:0] P_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] P_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  always_comb begin
    base = sp;
    if (sm == MODE_ACC && open_q)
      base = acc_q;
    sum = {base[PSUM_W-1], base}
        + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
    ovf = sum[SUM_W-1] ^ sum[SUM_W-2];
`ifdef PE_SATURATE_EN
    res = sum[PSUM_W-1:0];
    if (ovf)
      res = sum[SUM_W-1] ? P_MIN : P_MAX;
`else
    res = sum[PSUM_W-1:0];
`endif
    grp_ovf = ovf | (open_q & acc_ovf_q);
  end

  // Only the first group beat may take the bias; open_q steers that.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_psum     <= '0;
      o_psum_val <= 1'b0;
      o_ovf      <= 1'b0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      open_q     <= 1'b0;
    end else begin
      o_psum_val <= 1'b0;
      o_ovf      <= 1'b0;
      if (sv) begin
        if (sm == MODE_PASS) begin
          o_psum     <= res;
          o_psum_val <= 1'b1;
          o_ovf      <= ovf;
        end else if (sl) begin
          o_psum     <= res;
          o_psum_val <= 1'b1;
          o_ovf      <= grp_ovf;
          acc_q      <= '0;
          acc_ovf_q  <= 1'b0;
          open_q     <= 1'b0;
        end else begin
          acc_q      <= res;
          acc_ovf_q  <= grp_ovf;
          open_q     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Directed table-driven bench for pe_mac_acc (24-bit and 16-bit psum).
// Expected values follow the PE_SATURATE_EN build setting.
module tb_pe_mac_acc;

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_data, a_w;
  logic        a_dv, a_wv, a_m, a_l;
  logic [23:0] a_p, a_o;
  logic        a_ov, a_of;

  logic [7:0]  b_data, b_w;
  logic        b_dv, b_wv, b_m, b_l;
  logic [15:0] b_p, b_o;
  logic        b_ov, b_of;

  pe_mac_acc u_a (
    .clk          (clk),
    .rst          (rst),
    .i_data       (a_data),
    .i_data_val   (a_dv),
    .i_weight     (a_w),
    .i_weight_val (a_wv),
    .i_psum       (a_p),
    .i_mode       (a_m),
    .i_last       (a_l),
    .o_psum       (a_o),
    .o_psum_val   (a_ov),
    .o_ovf        (a_of)
  );

  pe_mac_acc #(.PSUM_W(16)) u_b (
    .clk          (clk),
    .rst          (rst),
    .i_data       (b_data),
    .i_data_val   (b_dv),
    .i_weight     (b_w),
    .i_weight_val (b_wv),
    .i_psum       (b_p),
    .i_mode       (b_m),
    .i_last       (b_l),
    .o_psum       (b_o),
    .o_psum_val   (b_ov),
    .o_ovf        (b_of)
  );

  typedef struct {
    int     c;
    longint v;
    logic   o;
  } ev_t;

  typedef struct {
    logic dv, m, l, wv;
    int   d, w, p;
    logic ev;
    int   ep;
    logic eo;
  } vec_t;

  int   cyc = 0;
  ev_t  aq[$];
  ev_t  bq[$];
  vec_t tv[$];
  int   iss[$];
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_ov) aq.push_back('{cyc, longint'($signed(a_o)), a_of});
    if (b_ov) bq.push_back('{cyc, longint'($signed(b_o)), b_of});
  end

  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(logic dv, logic m, logic l, int d, int w,
                              logic wv, int p, logic ev, int ep, logic eo);
    vec_t v;
    v.dv = dv; v.m = m; v.l = l; v.d = d; v.w = w; v.wv = wv;
    v.p = p; v.ev = ev; v.ep = ep; v.eo = eo;
    tv.push_back(v);
  endfunction

  task automatic drive_a(input vec_t v);
    a_dv = v.dv; a_m = v.m; a_l = v.l; a_wv = v.wv;
    a_data = v.d[7:0]; a_w = v.w[7:0]; a_p = v.p[23:0];
  endtask

  task automatic idle_a();
    a_dv = 0; a_wv = 0; a_m = 0; a_l = 0;
  endtask

  task automatic check_ev(input string n, input ev_t e,
                          input int icyc, input longint ev, input logic eo);
    chk({n, " psum"}, e.v, ev);
    chk({n, " ovf"}, longint'(e.o), longint'(eo));
    chk({n, " lat"}, e.c, icyc + 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t v;
    ev_t  e;
    int   n0, c0;
    rst = 0;
    idle_a();
    a_data = 0; a_w = 0; a_p = 0;
    b_dv = 0; b_wv = 0; b_m = 0; b_l = 0;
    b_data = 0; b_w = 0; b_p = 0;
    repeat (3) step();
    chk("rst a_val", longint'(a_ov), 0);
    chk("rst a_psum", longint'(a_o), 0);
    chk("rst a_ovf", longint'(a_of), 0);
    chk("rst b_val", longint'(b_ov), 0);
    rst = 1;
    step();

    add(1, 0, 0, 3, -2, 1, 10, 1, 4, 0);
    add(1, 1, 0, 1, 2, 1, 5, 0, 0, 0);
    add(1, 1, 0, 2, 2, 0, 999, 0, 0, 0);
    add(1, 1, 1, 3, 2, 0, 999, 1, 17, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      int w;
      w = (i < 4) ? 3 : -5;
      add(1, 0, 0, i, w, (i == 1 || i == 4), 100, 1, 100 + w * i, 0);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 7, 1, 0, 1, 1, 8, 0);
    add(1, 1, 1, 5, 1, 0, 0, 1, 9, 0);
    add(1, 0, 0, -128, -128, 1, 0, 1, 16384, 0);
    add(1, 0, 0, 127, -128, 1, 0, 1, -16256, 0);
    add(1, 0, 0, 0, 1, 1, 8388607, 1, 8388607, 0);
    add(1, 0, 0, -1, 1, 0, -8388608, 1, SAT ? -8388608 : 8388607, 1);
    add(1, 1, 0, 1, 1, 0, 8388607, 0, 0, 0);
    add(1, 1, 1, 2, 1, 0, 0, 1, SAT ? 8388607 : -8388606, 1);
    add(1, 1, 1, 3, 1, 0, -10, 1, -7, 0);

    foreach (tv[i]) begin
      iss.push_back(cyc);
      drive_a(tv[i]);
      step();
    end
    idle_a();
    repeat (10) step();

    foreach (tv[i]) begin
      if (tv[i].ev) begin
        if (aq.size() == 0) begin
          chk($sformatf("row%0d present", i), 0, 1);
        end else begin
          e = aq.pop_front();
          check_ev($sformatf("row%0d", i), e, iss[i], tv[i].ep, tv[i].eo);
        end
      end
    end
    chk("extra outputs", aq.size(), 0);

    // open a group, put 3 PASS beats in flight, then pulse reset
    v = '{1, 1, 0, 1, 10, 1, 100, 0, 0, 0};
    drive_a(v);
    step();
    idle_a();
    repeat (8) step();
    n0 = aq.size();
    for (int i = 0; i < 3; i++) begin
      v = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      drive_a(v);
      step();
    end
    idle_a();
    rst = 0;
    step();
    rst = 1;
    repeat (10) step();
    chk("no out after rst", aq.size(), n0);
    v = '{1, 1, 0, 1, 2, 1, 7, 0, 0, 0};
    v.l = 1;
    v.d = 2;
    v.w = 1;
    c0 = cyc;
    drive_a(v);
    step();
    idle_a();
    repeat (8) step();
    if (aq.size() != n0 + 1) begin
      chk("fresh group count", aq.size(), n0 + 1);
    end else begin
      e = aq.pop_front();
      check_ev("fresh group", e, c0, 9, 0);
    end

    // 16-bit psum instance: wrap/saturate boundary
    c0 = cyc;
    b_dv = 1; b_m = 0; b_l = 0; b_wv = 1; b_w = 8'd1;
    b_data = 8'd1; b_p = 16'd32767;
    step();
    b_p = 16'd32766; b_wv = 0;
    step();
    b_dv = 0;
    repeat (8) step();
    if (bq.size() != 2) begin
      chk("b count", bq.size(), 2);
    end else begin
      e = bq.pop_front();
      check_ev("b ovf", e, c0, SAT ? 32767 : -32768, 1);
      e = bq.pop_front();
      check_ev("b max", e, c0 + 1, 32767, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
